// File: rtl/audio_out_fifo_if.sv
// audio_out_fifo_if: stereo sample stream between the filter, the output FIFO and the codec.
//   slave  modport: FIFO side. It takes in_valid/in_left/in_right/write_ready and drives
//                   in_ready, write, writedata_left/right, count and overflow.
//   master modport: environment side, with the opposite directions.
interface audio_out_fifo_if #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 3
);
    logic              in_valid;
    logic [DATA_W-1:0] in_left;
    logic [DATA_W-1:0] in_right;
    logic              in_ready;
    logic              write_ready;
    logic              write;
    logic [DATA_W-1:0] writedata_left;
    logic [DATA_W-1:0] writedata_right;
    logic [ADDR_W:0]   count;
    logic              overflow;

    modport slave (
        input  in_valid, in_left, in_right, write_ready,
        output in_ready, write, writedata_left, writedata_right, count, overflow
    );

    modport master (
        output in_valid, in_left, in_right, write_ready,
        input  in_ready, write, writedata_left, writedata_right, count, overflow
    );
endinterface

// File: rtl/audio_out_fifo.sv
// audio_out_fifo: circular FIFO of stereo sample pairs. It sits between the filter output and
// the codec write port.
//   CLOCK_50 : system clock. All state changes on the rising edge.
//   reset    : synchronous, active-high. Clears pointers, count and overflow.
//   bus      : audio_out_fifo_if.slave, carrying:
//              in_valid/in_left/in_right/in_ready     - filter-side push handshake
//              write/write_ready/writedata_left/right - codec-side pop handshake
//              count (0..DEPTH) and the sticky overflow flag
// All outputs come only from registered state. There is no path from in_valid or write_ready
// to any output.
module audio_out_fifo #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    audio_out_fifo_if.slave   bus
);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_left  [DEPTH];
    logic [DATA_W-1:0] mem_right [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;

    logic not_empty;
    logic not_full;
    logic push;
    logic pop;

    assign not_empty = (count_q != '0);
    assign not_full  = (count_q != FULL_COUNT);
    assign push      = bus.in_valid && not_full;
    assign pop       = not_empty && bus.write_ready;

    assign bus.in_ready        = not_full;
    assign bus.write           = not_empty;
    assign bus.writedata_left  = not_empty ? mem_left[rd_ptr_q]  : '0;
    assign bus.writedata_right = not_empty ? mem_right[rd_ptr_q] : '0;
    assign bus.count           = count_q;
    assign bus.overflow        = overflow_q;

    // Storage is not cleared on reset. count_q = 0 hides any stale entries.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_left[wr_ptr_q]  <= bus.in_left;
                mem_right[wr_ptr_q] <= bus.in_right;
                wr_ptr_q            <= wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (ADDR_W + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (ADDR_W + 1)'(1);
            end
            // Fullness is judged on the registered count. A pop in the same cycle
            // does not save the incoming pair.
            if (bus.in_valid && !not_full) begin
                overflow_q <= 1'b1;
            end
        end
    end
endmodule

// File: doc/audio_out_fifo.md
Name: audio_out_fifo

Overview:
- Downstream neighbour of the `filter` stage.
- Buffers filtered stereo samples (24-bit left/right) and feeds them to the audio codec's write port.
- Decouples the filter's `read_ready`-paced output from the codec's `write_ready` pacing using a small circular FIFO.
- Flags dropped samples with a sticky overflow bit.

Parameters:
- DATA_W, 24, sample width per channel in bits.
- DEPTH, 8, FIFO entries (stereo pairs); must be a power of 2.
- ADDR_W, 3, log2(DEPTH); pointer width.

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  filter output pair valid this cycle.
- in_left  input  DATA_W  filtered left sample.
- in_right  input  DATA_W  filtered right sample.
- in_ready  output  1  FIFO can accept a pair (count < DEPTH).
- write_ready  input  1  codec can accept a pair this cycle.
- write  output  1  pair presented to codec (count > 0).
- writedata_left  output  DATA_W  head-of-FIFO left sample.
- writedata_right  output  DATA_W  head-of-FIFO right sample.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a valid pair was dropped because the FIFO was full.

Behaviour:
- Reset (reset=1 at a rising edge):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Derived outputs follow: write=0, in_ready=1, writedata_*=0.
  - Memory contents need not be cleared.
  - Reset overrides push and pop in the same cycle.
- Reset mid-operation: all buffered pairs are discarded and state is as after reset. Next cycle behaves as empty.
- Derived outputs (combinational from registered state only; no combinational path from in_valid or write_ready):
  - in_ready = (count != DEPTH).
  - write = (count != 0).
  - writedata_* = mem[rd_ptr] when count != 0, else 0.
- push = in_valid && in_ready.
  - Writes {in_left, in_right} to mem[wr_ptr].
  - wr_ptr increments modulo DEPTH.
- pop = write && write_ready.
  - Head pair is consumed at that edge.
  - rd_ptr increments modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Full (count=DEPTH) with in_valid=1:
  - Pair is dropped and overflow is set to 1. It stays 1 until reset.
  - This applies even if a pop occurs in the same cycle, because in_ready is judged on registered count.
- Empty (count=0):
  - write=0, so write_ready is ignored and no pop occurs.
  - A push makes write=1 and writedata = pushed pair on the next cycle (1-cycle latency, no bypass).
- Simultaneous push and pop with 0<count<DEPTH:
  - Both pointers advance.
  - Ordering is strictly FIFO.
- Wrap-around: pointers roll DEPTH-1 -> 0 seamlessly; no data loss or duplication across the wrap.
- Arithmetic: samples are stored and forwarded bit-exact (no sign handling, scaling or truncation).
- The implementation holds no state machine beyond pointers, count and overflow. It must be a synthesizable single always block for registers plus continuous assigns.

Test Plan:
- Reset behaviour:
  - Stimulus: hold reset=1 for 2 cycles with in_valid=1 and write_ready=1.
  - Required: count=0, write=0, in_ready=1, writedata_*=0, overflow=0.
- Single pair latency:
  - Stimulus: empty FIFO, write_ready=0; push L=8, R=16 for one cycle.
  - Required: next cycle write=1, writedata_left=8, writedata_right=16, count=1.
  - Then raise write_ready for 1 cycle. Required: count=0, write=0 the cycle after.
- Fill and overflow:
  - Stimulus: write_ready=0; push 9 pairs L=8,16,8,32,8,16,8,8,24.
  - Required: count=8 and in_ready=0 after the 8th push; 9th pair (24) dropped; overflow=1.
  - Then drain with write_ready=1. Required: output sequence 8,16,8,32,8,16,8,8; overflow stays 1.
- Simultaneous push/pop:
  - Stimulus: count=3, write_ready=1, push every cycle for 10 cycles.
  - Required: count stays 3 throughout and output order equals input order.
- Wrap-around:
  - Stimulus: stream 20 pairs (L=i, R=i+100) with write_ready toggling 1,0,1,0.
  - Required: all 20 pairs are received in order with none missing or duplicated, and overflow=0.
- Reset mid-stream:
  - Stimulus: with count=5, assert reset for 1 cycle.
  - Required: count=0 and write=0 the next cycle.
  - A subsequent push of L=42 appears alone at the head after 1 cycle.
